// File: rtl/mmu_translate_if.sv
// CPU-side bus of the MMU translate stage.
// master drives the CPU address/data/strobe, slave returns translation and readback.
interface mmu_translate_if;
   logic [15:0] i_cpu_addr;
   logic [7:0]  i_cpu_data;
   logic        i_cpu_we;
   logic [7:0]  o_cpu_data;
   logic [24:0] o_addr;
   logic        o_config_reg_sel;

   modport master (
      output i_cpu_addr,
      output i_cpu_data,
      output i_cpu_we,
      input  o_cpu_data,
      input  o_addr,
      input  o_config_reg_sel
   );

   modport slave (
      input  i_cpu_addr,
      input  i_cpu_data,
      input  i_cpu_we,
      output o_cpu_data,
      output o_addr,
      output o_config_reg_sel
   );
endinterface

// File: rtl/mmu_translate.sv
// 16-entry 4 KiB page MMU mapping the 6502 bus into 25-bit physical space.
// Page table is programmed through a 4-byte config window.
module mmu_translate #(
   parameter logic [15:0] CFG_BASE     = 16'hEFE0,
   parameter logic        RESET_ENABLE = 1'b0
) (
   input logic           i_clk,
   input logic           i_rst_n,
   mmu_translate_if.slave bus
);

   logic        ctrl_en;
   logic        ctrl_ai;
   logic [3:0]  index;
   logic [7:0]  lo_stage;
   logic [12:0] pt [16];

   logic        cfg_hit;
   logic [1:0]  off;
   logic [3:0]  page;
   logic [7:0]  rd_val;
   logic [24:0] xlat;

   assign cfg_hit = (bus.i_cpu_addr[15:2] == CFG_BASE[15:2]);
   assign off     = bus.i_cpu_addr[1:0];
   assign page    = bus.i_cpu_addr[15:12];

   always_comb begin
      xlat = {9'b0, bus.i_cpu_addr};
      if (ctrl_en)
         xlat = {pt[page], bus.i_cpu_addr[11:0]};
   end

   // DATA_LO/HI read the committed entry, never the staging byte
   always_comb begin
      rd_val = 8'h00;
      unique case (off)
         2'd0: rd_val = {6'b0, ctrl_ai, ctrl_en};
         2'd1: rd_val = {4'b0, index};
         2'd2: rd_val = pt[index][7:0];
         2'd3: rd_val = {3'b0, pt[index][12:8]};
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         ctrl_en              <= RESET_ENABLE;
         ctrl_ai              <= 1'b0;
         index                <= 4'd0;
         lo_stage             <= 8'h00;
         bus.o_addr           <= 25'd0;
         bus.o_config_reg_sel <= 1'b0;
         bus.o_cpu_data       <= 8'h00;
         for (int i = 0; i < 16; i++)
            pt[i] <= 13'(i);
      end else begin
         bus.o_addr           <= xlat;
         bus.o_config_reg_sel <= cfg_hit;
         bus.o_cpu_data       <= cfg_hit ? rd_val : 8'h00;
         if (bus.i_cpu_we && cfg_hit) begin
            unique case (off)
               2'd0: begin
                  ctrl_en <= bus.i_cpu_data[0];
                  ctrl_ai <= bus.i_cpu_data[1];
               end
               2'd1: index    <= bus.i_cpu_data[3:0];
               2'd2: lo_stage <= bus.i_cpu_data;
               2'd3: begin
                  pt[index] <= {bus.i_cpu_data[4:0], lo_stage};
                  if (ctrl_ai)
                     index <= index + 4'd1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mmu_translate.sv
// Scoreboard bench for mmu_translate: stimulus queues expectations,
// a monitor pops one per clock and compares the registered outputs.
module tb_mmu_translate;

   logic clk;
   logic rst_n;
   mmu_translate_if bus ();

   mmu_translate #(
      .CFG_BASE     (16'hEFE0),
      .RESET_ENABLE (1'b0)
   ) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   typedef struct {
      bit          chk;
      int          id;
      logic [24:0] a;
      logic        s;
      logic [7:0]  d;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   vid      = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         if (e.chk) begin
            checks++;
            if (bus.o_addr !== e.a) begin
               failures++;
               $display("FAIL v%0d o_addr got %h exp %h", e.id, bus.o_addr, e.a);
            end
            checks++;
            if (bus.o_config_reg_sel !== e.s) begin
               failures++;
               $display("FAIL v%0d sel got %b exp %b", e.id, bus.o_config_reg_sel, e.s);
            end
            checks++;
            if (bus.o_cpu_data !== e.d) begin
               failures++;
               $display("FAIL v%0d cpu_data got %h exp %h", e.id, bus.o_cpu_data, e.d);
            end
         end
      end
   end

   task automatic step(input logic [15:0] a, input logic [7:0] d,
                       input logic we, input logic rn, input bit chk,
                       input logic [24:0] ea, input logic es,
                       input logic [7:0] ed);
      exp_t e;
      @(negedge clk);
      bus.i_cpu_addr = a;
      bus.i_cpu_data = d;
      bus.i_cpu_we   = we;
      rst_n          = rn;
      vid++;
      e.chk = chk;
      e.id  = vid;
      e.a   = ea;
      e.s   = es;
      e.d   = ed;
      q.push_back(e);
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      step(a, d, 1'b1, 1'b1, 1'b0, 25'd0, 1'b0, 8'h00);
   endtask

   task automatic rd(input logic [15:0] a, input logic [24:0] ea,
                     input logic es, input logic [7:0] ed);
      step(a, 8'h00, 1'b0, 1'b1, 1'b1, ea, es, ed);
   endtask

   initial begin
      int guard;
      rst_n          = 1'b0;
      bus.i_cpu_addr = 16'h0000;
      bus.i_cpu_data = 8'h00;
      bus.i_cpu_we   = 1'b0;

      // reset state, even with a live address present
      step(16'h1234, 8'h00, 1'b0, 1'b0, 1'b0, 25'd0, 1'b0, 8'h00);
      step(16'h1234, 8'h00, 1'b0, 1'b0, 1'b1, 25'd0, 1'b0, 8'h00);

      rd(16'h1234, 25'h0001234, 1'b0, 8'h00);
      rd(16'hEFE0, 25'h000EFE0, 1'b1, 8'h00);

      // program entry 2, enable, translate on the very next cycle
      wr(16'hEFE1, 8'h02);
      wr(16'hEFE2, 8'hCD);
      wr(16'hEFE3, 8'h1A);
      wr(16'hEFE0, 8'h01);
      rd(16'h2ABC, 25'h1ACDABC, 1'b0, 8'h00);
      rd(16'hEFE2, 25'h000EFE2, 1'b1, 8'hCD);
      rd(16'hEFE3, 25'h000EFE3, 1'b1, 8'h1A);
      rd(16'hEFE1, 25'h000EFE1, 1'b1, 8'h02);
      rd(16'hEFE0, 25'h000EFE0, 1'b1, 8'h01);
      rd(16'h1234, 25'h0001234, 1'b0, 8'h00);

      // autoinc across the 15 -> 0 wrap
      wr(16'hEFE0, 8'h03);
      wr(16'hEFE1, 8'h0F);
      wr(16'hEFE2, 8'h11);
      wr(16'hEFE3, 8'h02);
      wr(16'hEFE2, 8'h22);
      wr(16'hEFE3, 8'h1F);
      rd(16'hEFE1, 25'h000EFE1, 1'b1, 8'h01);
      rd(16'h0456, 25'h1F22456, 1'b0, 8'h00);
      rd(16'hF00F, 25'h021100F, 1'b0, 8'h00);
      rd(16'hEFE2, 25'h000EFE2, 1'b1, 8'h01);
      rd(16'hEFE3, 25'h000EFE3, 1'b1, 8'h00);

      // DATA_LO alone leaves the table untouched; commit applies next cycle
      wr(16'hEFE1, 8'h05);
      wr(16'hEFE2, 8'hAB);
      rd(16'h5123, 25'h0005123, 1'b0, 8'h00);
      wr(16'hEFE3, 8'h03);
      rd(16'h5123, 25'h03AB123, 1'b0, 8'h00);

      // commit to the entry translated in the same cycle (page 14)
      wr(16'hEFE1, 8'h0E);
      wr(16'hEFE2, 8'h34);
      step(16'hEFE3, 8'h05, 1'b1, 1'b1, 1'b1, 25'h000EFE3, 1'b1, 8'h00);
      rd(16'hEFE3, 25'h0534FE3, 1'b1, 8'h02);

      // window edges
      rd(16'hEFE4, 25'h0534FE4, 1'b0, 8'h00);
      rd(16'hEFDF, 25'h0534FDF, 1'b0, 8'h00);

      // register masking and non-window writes
      wr(16'hEFE1, 8'hF7);
      rd(16'hEFE1, 25'h0534FE1, 1'b1, 8'h07);
      wr(16'h1FE3, 8'h1F);
      rd(16'hEFE3, 25'h0534FE3, 1'b1, 8'h00);
      rd(16'hEFE1, 25'h0534FE1, 1'b1, 8'h07);
      wr(16'hEFE0, 8'hFE);
      rd(16'hEFE0, 25'h000EFE0, 1'b1, 8'h02);
      rd(16'h0456, 25'h0000456, 1'b0, 8'h00);

      // reset coincident with a DATA_HI write
      wr(16'hEFE0, 8'h01);
      wr(16'hEFE1, 8'h00);
      step(16'hEFE3, 8'h1F, 1'b1, 1'b0, 1'b1, 25'd0, 1'b0, 8'h00);
      rd(16'hEFE1, 25'h000EFE1, 1'b1, 8'h00);
      rd(16'hEFE0, 25'h000EFE0, 1'b1, 8'h00);
      rd(16'hEFE2, 25'h000EFE2, 1'b1, 8'h00);
      rd(16'hEFE3, 25'h000EFE3, 1'b1, 8'h00);
      wr(16'hEFE0, 8'h01);
      rd(16'h0456, 25'h0000456, 1'b0, 8'h00);
      rd(16'h5123, 25'h0005123, 1'b0, 8'h00);
      rd(16'h2ABC, 25'h0002ABC, 1'b0, 8'h00);

      guard = 0;
      while (q.size() > 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain queue left %0d exp 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mmu_translate.md
Name: mmu_translate

Overview:
- Memory-management stage between the 6502 CPU bus and the physical address decoder.
- Maps the 16-bit CPU address into the 25-bit physical space using a 16-entry page table of 4 KiB pages.
- Drives the decoder's physical address and config-register-select inputs.
- Holds the page table, programmed by the CPU through a 4-byte config window in CPU address space.

Parameters:
- CFG_BASE, 16'hEFE0: CPU address of the config window (4 bytes, must be 4-aligned).
- RESET_ENABLE, 1'b0: reset value of CTRL.enable.

Ports:
- i_clk  input  1  system clock
- i_rst_n  input  1  reset; synchronous, active-low
- i_cpu_addr  input  16  CPU address
- i_cpu_data  input  8  CPU write data
- i_cpu_we  input  1  write strobe; one-cycle pulse, qualifies i_cpu_addr/i_cpu_data
- o_cpu_data  output  8  registered readback of config window
- o_addr  output  25  registered physical address to decoder
- o_config_reg_sel  output  1  registered; high when i_cpu_addr is inside the config window

Behaviour:
- Window decode:
  - cfg_hit = (i_cpu_addr[15:2] == CFG_BASE[15:2]).
  - Register offset is i_cpu_addr[1:0].
  - The window is always decoded on the untranslated CPU address.
- Config registers:
  - 0 CTRL: bit0 enable, bit1 autoinc; bits 7:2 read 0, writes ignored.
  - 1 INDEX: bits 3:0 select the page-table entry; upper bits read 0.
  - 2 DATA_LO: a write stores bits 7:0 into staging register lo_stage only; the table is not changed.
  - 3 DATA_HI: a write commits table[INDEX] <= {i_cpu_data[4:0], lo_stage}. If autoinc = 1, INDEX <= INDEX+1, wrapping 15 -> 0.
- Page table: 16 entries x 13 bits (frame number = physical address bits 24:12).
- Translation, registered with 1-cycle latency:
  - If enable = 1: o_addr <= {table[i_cpu_addr[15:12]], i_cpu_addr[11:0]}.
  - If enable = 0: o_addr <= {9'b0, i_cpu_addr}.
  - o_config_reg_sel <= cfg_hit, same cycle as o_addr.
  - o_addr is still computed on cfg_hit; the decoder qualifies it with o_config_reg_sel.
- Readback, registered with 1-cycle latency, updated every cycle:
  - o_cpu_data <= value of register at i_cpu_addr[1:0] if cfg_hit, else 8'h00.
  - DATA_LO reads table[INDEX][7:0] (not lo_stage).
  - DATA_HI reads {3'b0, table[INDEX][12:8]}.
- Write timing:
  - A write registers at the clock edge where i_cpu_we = 1 and cfg_hit = 1.
  - A write with cfg_hit = 0 has no effect in this block.
- Simultaneous events:
  - A translation in the same cycle as a DATA_HI commit to the same entry uses the old entry.
  - The new entry is used from the next cycle.
  - A readback in the same cycle as a write returns the pre-write value.
  - A CTRL write changes the translation mode starting the following cycle.
- Reset (i_rst_n = 0 at a clock edge):
  - table[i] <= {9'b0, i[3:0]}, i.e. identity map.
  - CTRL <= {autoinc = 0, enable = RESET_ENABLE}.
  - INDEX <= 0, lo_stage <= 0.
  - o_addr <= 0, o_config_reg_sel <= 0, o_cpu_data <= 0.
  - Reset during a write: reset wins; the write is dropped.
- Identity reset contents give enable = 0 and enable = 1 the same mapping until the table is reprogrammed.
- No combinational path from inputs to outputs.

Test Plan:
1. Reset, then i_cpu_addr = 16'h1234 -> o_addr = 25'h0001234 one cycle later; o_config_reg_sel = 0; o_cpu_data = 0.
2. Write INDEX = 2, DATA_LO = 8'hCD, DATA_HI = 8'h1A, CTRL = 8'h01; then i_cpu_addr = 16'h2ABC -> o_addr = 25'h1ACDABC; readback of DATA_LO/DATA_HI gives 8'hCD/8'h1A.
3. CTRL = 8'h03 (autoinc), INDEX = 15, two LO/HI pairs -> table[15] and table[0] written; INDEX reads 8'h01 afterwards; page 0 translates to the new frame.
4. Translate page 5 in the same cycle as a DATA_HI commit to entry 5 -> that o_addr uses the old frame; the next cycle uses the new frame.
5. i_cpu_addr = 16'hEFE3 -> o_config_reg_sel = 1 regardless of the page-14 mapping; 16'hEFE4 -> o_config_reg_sel = 0.
6. Assert i_rst_n = 0 coincident with a DATA_HI write -> table identity, CTRL = 0, INDEX = 0 after the edge; the write is not applied.
